// File: rtl/pin_pkg.sv
// Shared constants and types for the pin pulse generation path.
package pin_pkg;

  localparam int SLOTS       = 8;
  localparam int PTIME_W     = 3;
  localparam int WIDTH_W_DEF = 8;

  // One queued pulse request; the FIFO stores requests in this {ptime, width} bit layout.
  typedef struct packed {
    logic [PTIME_W-1:0]     ptime;
    logic [WIDTH_W_DEF-1:0] width;
  } pulse_req_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } gen_state_t;

endpackage

// File: rtl/pin_req_fifo.sv
// Small synchronous request FIFO; entries are {ptime, width} packed like pulse_req_t.
module pin_req_fifo
  import pin_pkg::*;
#(
  parameter int WIDTH_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk300,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [PTIME_W+WIDTH_W-1:0] din,
  output logic                       full,
  output logic                       empty,
  output logic [PTIME_W+WIDTH_W-1:0] dout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [PTIME_W+WIDTH_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  // Storage array; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk300) begin
    if (push && !full) begin
      mem[wptr[AW-1:0]] <= din;
    end
  end

  // Read/write pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk300) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop && !empty) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/pin_pulse_gen.sv
// Turns queued (ptime, width) pulse requests into 8-slot words for an 8:1 serializer.
module pin_pulse_gen
  import pin_pkg::*;
#(
  parameter int WIDTH_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk300,
  input  logic               rst,
  input  logic               str_in,
  input  logic [PTIME_W-1:0] ptime_in,
  input  logic [WIDTH_W-1:0] width_in,
  output logic               ready,
  output logic [SLOTS-1:0]   ser_word,
  output logic               busy
);

  localparam int CALC_W = (WIDTH_W + 1 > 4) ? WIDTH_W + 1 : 4;
  localparam int REQ_W  = PTIME_W + WIDTH_W;
  localparam logic [SLOTS-1:0]  ALL_ONES = '1;
  localparam logic [CALC_W-1:0] SLOTS_C  = CALC_W'(SLOTS);

  logic               full;
  logic               empty;
  logic               pop;
  logic [REQ_W-1:0]   fifo_dout;

  // pend marks a request popped on the previous edge whose first word is built now
  logic               pend;
  logic [PTIME_W-1:0] req_ptime;
  logic [WIDTH_W-1:0] req_width;

  gen_state_t         state;
  gen_state_t         nxt_state;
  logic [CALC_W-1:0]  rem;
  logic [CALC_W-1:0]  nxt_rem;
  logic [CALC_W-1:0]  avail;
  logic [CALC_W-1:0]  req_w_ext;
  logic [CALC_W-1:0]  first_rem;
  logic [2:0]         tail_shift;
  logic [2:0]         last_shift;
  logic [SLOTS-1:0]   nxt_word;
  logic               out_busy;

  pin_req_fifo #(
    .WIDTH_W    (WIDTH_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk300 (clk300),
    .rst    (rst),
    .push   (str_in),
    .pop    (pop),
    .din    ({ptime_in, width_in}),
    .full   (full),
    .empty  (empty),
    .dout   (fifo_dout)
  );

  // Next word, remaining width and state: first word of a fresh pulse, or a continuation word.
  always_comb begin
    nxt_state  = IDLE;
    nxt_rem    = '0;
    nxt_word   = '0;
    req_w_ext  = CALC_W'(req_width);
    avail      = SLOTS_C - CALC_W'(req_ptime);
    first_rem  = req_w_ext - avail;
    tail_shift = 3'(avail - req_w_ext);
    last_shift = 3'(SLOTS_C - rem);
    if (pend) begin
      if (req_w_ext == '0) begin
        nxt_word = '0;
      end else if (req_w_ext > avail) begin
        nxt_word  = ALL_ONES << req_ptime;
        nxt_rem   = first_rem;
        nxt_state = ACTIVE;
      end else begin
        nxt_word = (ALL_ONES << req_ptime) & (ALL_ONES >> tail_shift);
      end
    end else if (state == ACTIVE) begin
      if (rem >= SLOTS_C) begin
        nxt_word  = ALL_ONES;
        nxt_rem   = rem - SLOTS_C;
        nxt_state = (rem == SLOTS_C) ? IDLE : ACTIVE;
      end else begin
        nxt_word = ALL_ONES >> last_shift;
      end
    end
  end

  // Fetch the next request whenever the word being registered now ends the current pulse.
  assign pop   = !empty && (nxt_state == IDLE);
  assign ready = !full;
  assign busy  = !empty || pend || out_busy || (state == ACTIVE);

  // Generator registers and the output word; reset abandons any pulse in flight.
  always_ff @(posedge clk300) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= '0;
      pend      <= 1'b0;
      req_ptime <= '0;
      req_width <= '0;
      ser_word  <= '0;
      out_busy  <= 1'b0;
    end else begin
      state    <= nxt_state;
      rem      <= nxt_rem;
      ser_word <= nxt_word;
      out_busy <= pend || (state == ACTIVE);
      pend     <= pop;
      if (pop) begin
        {req_ptime, req_width} <= fifo_dout;
      end
    end
  end

endmodule
